rx_decoder: RTL and testbench

USB full-speed receive-side line decoder. It is the counterpart of the transmit NRZI encoder.
- Synchronises the raw D+/D- pair.
- Recovers bit timing from line transitions.
- NRZI-decodes the sampled line and removes stuffed bits.
- Flags end-of-packet (EOP) and stuffing violations.
- Its output feeds the receive shift register and the receive control FSM.

---
 rtl/rx_decoder.sv | 128 ++++++++++++
 tb/tb_rx_decoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_decoder.sv
// USB full-speed receive line decoder. It synchronises D+/D-, recovers the
// bit clock from D+ transitions, samples once per bit period, NRZI-decodes
// the samples and strips stuffed bits. The single-cycle strobes bit_valid,
// eop and stuff_err are registered, and at most one of them fires per cycle.
module rx_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PT    = 3,
  parameter int MAX_ONES     = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_in,
  input  logic d_minus_in,
  input  logic enable,
  output logic rx_bit,
  output logic bit_valid,
  output logic eop,
  output logic stuff_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int OW = $clog2(MAX_ONES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_SMP  = CW'(SAMPLE_PT);
  localparam logic [OW-1:0] ONES_MAX = OW'(MAX_ONES);

  // Index [0] is the metastability flop and [1] is the synced line.
  logic [1:0]    dp_sync_q, dp_sync_d, dm_sync_q, dm_sync_d;
  logic          dp_prev_q, dp_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_dp_q, last_dp_d;
  logic [OW-1:0] ones_q, ones_d;
  logic          se0_seen_q, se0_seen_d;
  logic          rx_bit_q, rx_bit_d, bit_valid_q, bit_valid_d;
  logic          eop_q, eop_d, stuff_err_q, stuff_err_d;

  logic d_plus_s, d_minus_s, line_edge, sample, se0, dec_bit;

  assign rx_bit    = rx_bit_q;
  assign bit_valid = bit_valid_q;
  assign eop       = eop_q;
  assign stuff_err = stuff_err_q;

  // Synchroniser, edge detect and bit timer: an edge re-phases the timer.
  always_comb begin
    dp_sync_d = {dp_sync_q[0], d_plus_in};
    dm_sync_d = {dm_sync_q[0], d_minus_in};
    d_plus_s  = dp_sync_q[1];
    d_minus_s = dm_sync_q[1];
    dp_prev_d = d_plus_s;
    line_edge = (d_plus_s != dp_prev_q);
    if (line_edge)              cnt_d = '0;
    else if (cnt_q == CNT_LAST) cnt_d = '0;
    else                        cnt_d = cnt_q + CW'(1);
    // A sample coinciding with an edge still uses the current count.
    sample  = enable && (cnt_q == CNT_SMP);
    se0     = !d_plus_s && !d_minus_s;
    dec_bit = (d_plus_s == last_dp_q);
  end

  // NRZI decode, unstuffing and EOP detection on each sample.
  always_comb begin
    last_dp_d   = last_dp_q;
    ones_d      = ones_q;
    se0_seen_d  = se0_seen_q;
    rx_bit_d    = 1'b0;
    bit_valid_d = 1'b0;
    eop_d       = 1'b0;
    stuff_err_d = 1'b0;
    if (!enable) begin
      // Track the idle line so the first bit decodes against it.
      last_dp_d  = d_plus_s;
      ones_d     = '0;
      se0_seen_d = 1'b0;
    end else if (sample) begin
      if (se0) begin
        ones_d = '0;
        if (se0_seen_q) begin
          eop_d      = 1'b1;
          last_dp_d  = 1'b1;
          se0_seen_d = 1'b0;
        end else begin
          se0_seen_d = 1'b1;
        end
      end else begin
        se0_seen_d = 1'b0;
        last_dp_d  = d_plus_s;
        if (ones_q == ONES_MAX) begin
          // Bit after a full run of ones must be a stuffed 0; drop it either way.
          ones_d      = '0;
          stuff_err_d = dec_bit;
        end else begin
          bit_valid_d = 1'b1;
          rx_bit_d    = dec_bit;
          ones_d      = dec_bit ? ones_q + OW'(1) : '0;
        end
      end
    end
  end

  // State and output registers; reset puts the line at J.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_sync_q   <= 2'b11;
      dm_sync_q   <= 2'b00;
      dp_prev_q   <= 1'b1;
      cnt_q       <= '0;
      last_dp_q   <= 1'b1;
      ones_q      <= '0;
      se0_seen_q  <= 1'b0;
      rx_bit_q    <= 1'b0;
      bit_valid_q <= 1'b0;
      eop_q       <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      dp_sync_q   <= dp_sync_d;
      dm_sync_q   <= dm_sync_d;
      dp_prev_q   <= dp_prev_d;
      cnt_q       <= cnt_d;
      last_dp_q   <= last_dp_d;
      ones_q      <= ones_d;
      se0_seen_q  <= se0_seen_d;
      rx_bit_q    <= rx_bit_d;
      bit_valid_q <= bit_valid_d;
      eop_q       <= eop_d;
      stuff_err_q <= stuff_err_d;
    end
  end
endmodule

// File: tb/tb_rx_decoder.sv
// Bench for rx_decoder. A transmit-side model (NRZI encode + bit stuffing)
// turns random data into line symbols; the decoded event stream must match
// the original data, followed by the EOP marker.
module tb_rx_decoder;
  localparam int EV_EOP = 2;
  localparam int EV_ERR = 3;
  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;

  logic clk = 1'b0;
  logic n_rst, d_plus_in, d_minus_in, enable;
  logic rx_bit, bit_valid, eop, stuff_err;

  int checks = 0, failures = 0, cyc = 0, first_cyc = 0;
  int obs_ev[$], obs_cyc[$], exp_ev[$], data_q[$];
  logic [1:0] tx_syms[$];

  rx_decoder dut (
    .clk(clk), .n_rst(n_rst), .d_plus_in(d_plus_in), .d_minus_in(d_minus_in),
    .enable(enable), .rx_bit(rx_bit), .bit_valid(bit_valid), .eop(eop),
    .stuff_err(stuff_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Collect decoder events once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && (bit_valid | eop | stuff_err) === 1'b1) begin
      chk("onehot", 32'(bit_valid) + 32'(eop) + 32'(stuff_err), 1);
      obs_ev.push_back(bit_valid ? int'(rx_bit) : (eop ? EV_EOP : EV_ERR));
      obs_cyc.push_back(cyc);
    end
  end

  task automatic set_line(input logic [1:0] s);
    {d_plus_in, d_minus_in} = s;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_data(input int n);
    data_q.delete();
    for (int i = 0; i < n; i++) data_q.push_back(($urandom_range(0, 3) != 0) ? 1 : 0);
  endtask

  // Transmit model: SYNC + data_q, NRZI with a stuffed 0 after six 1s.
  task automatic build_packet(input bit with_eop);
    int raw[$];
    int ones = 0;
    bit lvl = 1'b1;
    tx_syms.delete();
    exp_ev.delete();
    raw = '{0, 0, 0, 0, 0, 0, 0, 1};
    foreach (data_q[i]) raw.push_back(data_q[i]);
    foreach (raw[i]) begin
      if (raw[i] == 0) lvl = ~lvl;
      tx_syms.push_back(lvl ? J : K);
      exp_ev.push_back(raw[i]);
      ones = (raw[i] == 1) ? ones + 1 : 0;
      if (ones == 6) begin
        lvl = ~lvl;
        tx_syms.push_back(lvl ? J : K);
        ones = 0;
      end
    end
    if (with_eop) begin
      tx_syms.push_back(SE0);
      tx_syms.push_back(SE0);
      exp_ev.push_back(EV_EOP);
    end
  endtask

  // Phase the bit timer with a K/J pair while disabled, then open the
  // window on the first symbol so no idle-J bits are decoded.
  task automatic send(input int n, input bit keep_en);
    enable = 1'b0;
    set_line(K);
    wait_neg(8);
    set_line(J);
    wait_neg(8);
    for (int i = 0; i < n; i++) begin
      set_line(tx_syms[i]);
      if (i == 0) begin
        enable = 1'b1;
        first_cyc = cyc;
      end
      wait_neg(8);
    end
    if (!keep_en) begin
      enable = 1'b0;
      set_line(J);
    end
  endtask

  task automatic compare(input string tag);
    int n;
    n = (obs_ev.size() < exp_ev.size()) ? obs_ev.size() : exp_ev.size();
    chk({tag, "_count"}, obs_ev.size(), exp_ev.size());
    for (int i = 0; i < n; i++) chk($sformatf("%s_ev%0d", tag, i), obs_ev[i], exp_ev[i]);
  endtask

  task automatic clear_obs();
    obs_ev.delete();
    obs_cyc.delete();
  endtask

  task automatic run_packet(input string tag);
    clear_obs();
    send(tx_syms.size(), 1'b0);
    wait_neg(24);
    compare(tag);
  endtask

  // Wait (bounded) for a data strobe mid-packet; returns 1 if seen.
  task automatic wait_strobe(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      @(negedge clk);
      if (bit_valid === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    bit seen;
    int abort_cyc, late;
    n_rst = 1'b0;
    enable = 1'b0;
    set_line(J);

    // Reset held while the line and enable toggle: outputs stay low.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_line(2'($urandom));
      enable = 1'($urandom);
      chk("rst_out", 32'({rx_bit, bit_valid, eop, stuff_err}), 0);
    end
    @(negedge clk);
    enable = 1'b0;
    set_line(J);
    chk("rst_out_last", 32'({rx_bit, bit_valid, eop, stuff_err}), 0);

    // Idle J after reset with the window open: one 1 every 8 clocks and a
    // stuff error on every 7th sample. Samples land on posedges 4,12,..,100.
    clear_obs();
    n_rst = 1'b1;
    enable = 1'b1;
    repeat (100) @(posedge clk);
    #1 enable = 1'b0;
    wait_neg(10);
    exp_ev.delete();
    for (int i = 0; i < 13; i++) exp_ev.push_back((i % 7 == 6) ? EV_ERR : 1);
    compare("idle");

    // SYNC alone, then EOP; first strobe 7 posedges after driving the first K.
    data_q.delete();
    build_packet(1'b1);
    run_packet("sync");
    if (obs_cyc.size() > 0) chk("latency", obs_cyc[0] - first_cyc, 7);
    else chk("latency_none", 0, 1);

    // Directed stuffing: run of ones forces a stuffed transition, then a 0.
    data_q = '{1, 1, 1, 1, 1, 1, 0, 1, 0};
    build_packet(1'b1);
    run_packet("stuff");

    // Stuff error: hold the line after SYNC for 7 bit periods.
    data_q.delete();
    build_packet(1'b0);
    for (int i = 0; i < 7; i++) tx_syms.push_back(K);
    exp_ev.push_back(1); exp_ev.push_back(1); exp_ev.push_back(1);
    exp_ev.push_back(1); exp_ev.push_back(1);
    exp_ev.push_back(EV_ERR);
    exp_ev.push_back(1);
    run_packet("stuff_err");

    // EOP then K J K K with the window still open: decoded against J.
    rand_data(4);
    build_packet(1'b1);
    tx_syms.push_back(K); tx_syms.push_back(J);
    tx_syms.push_back(K); tx_syms.push_back(K);
    exp_ev.push_back(0); exp_ev.push_back(0);
    exp_ev.push_back(0); exp_ev.push_back(1);
    run_packet("eop_kj");

    // Random packets.
    for (int p = 0; p < 6; p++) begin
      rand_data($urandom_range(8, 40));
      build_packet(1'b1);
      run_packet($sformatf("rnd%0d", p));
    end

    // Abort by enable mid-packet: nothing after the following cycle.
    rand_data(16);
    build_packet(1'b1);
    clear_obs();
    send(10, 1'b1);
    set_line(tx_syms[10]);
    wait_strobe(seen);
    chk("abort_en_seen", 32'(seen), 1);
    abort_cyc = cyc;
    enable = 1'b0;
    set_line(J);
    wait_neg(24);
    late = 0;
    foreach (obs_cyc[i]) if (obs_cyc[i] > abort_cyc) late++;
    chk("abort_en_late", late, 0);
    foreach (obs_ev[i]) chk($sformatf("abort_en_ev%0d", i), obs_ev[i], exp_ev[i]);
    data_q.delete();
    build_packet(1'b1);
    run_packet("after_en_abort");

    // Abort by reset mid-packet: outputs drop without waiting for a clock.
    rand_data(16);
    build_packet(1'b1);
    clear_obs();
    send(10, 1'b1);
    set_line(tx_syms[10]);
    wait_strobe(seen);
    chk("abort_rst_seen", 32'(seen), 1);
    #2 n_rst = 1'b0;
    #1 chk("abort_rst_out", 32'({rx_bit, bit_valid, eop, stuff_err}), 0);
    wait_neg(2);
    enable = 1'b0;
    set_line(J);
    n_rst = 1'b1;
    wait_neg(8);
    data_q = '{1, 0, 1, 1, 0, 0, 1, 0};
    build_packet(1'b1);
    run_packet("after_rst_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
